// File: rtl/clock_mode_ctrl.sv
// Push-button mode/edit controller for the digital clock: debounced buttons drive
// display selection, a field-by-field time/date edit session and a one-cycle load request.
//
// state     | meaning
// TIME_DISP | showing hh:mm:ss
// DATE_DISP | showing date; up/down toggles year digits
// WEEK_DISP | showing weekday
// EDIT      | editing set_* field selected by edit_field
// COMMIT    | one cycle, load_req=1 with set_* stable
module clock_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES    = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       adjust_btn,
  input  logic       up_btn,
  input  logic       down_btn,
  input  logic [6:0] cur_year,
  input  logic [3:0] cur_month,
  input  logic [4:0] cur_day,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  output logic [6:0] set_year,
  output logic [3:0] set_month,
  output logic [4:0] set_day,
  output logic [4:0] set_hour,
  output logic [5:0] set_minute,
  output logic [5:0] set_second,
  output logic       load_req,
  output logic [1:0] display_sel,
  output logic       display_year,
  output logic       editing,
  output logic [2:0] edit_field,
  output logic [7:0] blink_mask
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  typedef enum logic [2:0] {TIME_DISP, DATE_DISP, WEEK_DISP, EDIT, COMMIT} state_t;
  state_t state;

  // Button index: 3=adjust, 2=mode, 1=up, 0=down.
  logic [3:0]    btn_raw, sync1, sync2, level, level_d, press;
  logic [DW-1:0] db_cnt [4];

  assign btn_raw = {adjust_btn, mode_btn, up_btn, down_btn};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 4'hF;
      sync2   <= 4'hF;
      level   <= 4'hF;
      level_d <= 4'hF;
      press   <= 4'h0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level_d & ~level;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic ev_adj, ev_mode, ev_up, ev_down, ev_step;
  assign ev_adj  = press[3];
  assign ev_mode = press[2] & ~press[3];
  assign ev_up   = press[1] & ~press[2] & ~press[3];
  assign ev_down = press[0] & ~press[1] & ~press[2] & ~press[3];
  assign ev_step = ev_up | ev_down;

  function automatic logic [4:0] days_in(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                    days_in = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: days_in = 5'd30;
      default:                 days_in = 5'd31;
    endcase
  endfunction

  logic [5:0] sec_adj, min_adj;
  logic [4:0] hour_adj, day_adj, dim_cur, dim_m, dim_y, day_m, day_y;
  logic [3:0] month_adj;
  logic [6:0] year_adj;
  logic [2:0] field_nxt;

  // ev_up selects the direction; these are only consumed on ev_up or ev_down.
  assign sec_adj   = ev_up ? ((set_second == 6'd59) ? 6'd0 : set_second + 6'd1)
                           : ((set_second == 6'd0) ? 6'd59 : set_second - 6'd1);
  assign min_adj   = ev_up ? ((set_minute == 6'd59) ? 6'd0 : set_minute + 6'd1)
                           : ((set_minute == 6'd0) ? 6'd59 : set_minute - 6'd1);
  assign hour_adj  = ev_up ? ((set_hour == 5'd23) ? 5'd0 : set_hour + 5'd1)
                           : ((set_hour == 5'd0) ? 5'd23 : set_hour - 5'd1);
  assign month_adj = ev_up ? ((set_month >= 4'd12) ? 4'd1 : set_month + 4'd1)
                           : ((set_month <= 4'd1) ? 4'd12 : set_month - 4'd1);
  assign year_adj  = ev_up ? ((set_year >= 7'd99) ? 7'd0 : set_year + 7'd1)
                           : ((set_year == 7'd0) ? 7'd99 : set_year - 7'd1);

  assign dim_cur = days_in(set_month, set_year[1:0] == 2'b00);
  assign dim_m   = days_in(month_adj, set_year[1:0] == 2'b00);
  assign dim_y   = days_in(set_month, year_adj[1:0] == 2'b00);
  assign day_adj = ev_up ? ((set_day >= dim_cur) ? 5'd1 : set_day + 5'd1)
                         : ((set_day <= 5'd1) ? dim_cur : set_day - 5'd1);
  assign day_m   = (set_day > dim_m) ? dim_m : set_day;
  assign day_y   = (set_day > dim_y) ? dim_y : set_day;

  assign field_nxt = (edit_field >= 3'd5) ? 3'd0 : edit_field + 3'd1;

  logic [BW-1:0] blink_cnt;
  logic          blink_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= TIME_DISP;
      edit_field   <= 3'd0;
      load_req     <= 1'b0;
      display_sel  <= 2'd0;
      display_year <= 1'b0;
      editing      <= 1'b0;
      set_year     <= 7'd0;
      set_month    <= 4'd1;
      set_day      <= 5'd1;
      set_hour     <= 5'd0;
      set_minute   <= 6'd0;
      set_second   <= 6'd0;
      blink_cnt    <= BW'(BLINK_CYCLES - 1);
      blink_off    <= 1'b0;
    end else begin
      load_req <= 1'b0;
      if (blink_cnt == '0) begin
        blink_cnt <= BW'(BLINK_CYCLES - 1);
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt - 1'b1;
      end

      case (state)
        TIME_DISP, DATE_DISP, WEEK_DISP: begin
          if (ev_adj) begin
            set_year     <= cur_year;
            set_month    <= cur_month;
            set_day      <= cur_day;
            set_hour     <= cur_hour;
            set_minute   <= cur_minute;
            set_second   <= cur_second;
            edit_field   <= 3'd0;
            state        <= EDIT;
            editing      <= 1'b1;
            display_sel  <= 2'd0;
            display_year <= 1'b0;
            blink_cnt    <= BW'(BLINK_CYCLES - 1);
            blink_off    <= 1'b0;
          end else if (ev_mode) begin
            display_year <= 1'b0;
            case (state)
              TIME_DISP: begin state <= DATE_DISP; display_sel <= 2'd1; end
              DATE_DISP: begin state <= WEEK_DISP; display_sel <= 2'd2; end
              default:   begin state <= TIME_DISP; display_sel <= 2'd0; end
            endcase
          end else if (ev_step && state == DATE_DISP) begin
            display_year <= ~display_year;
          end
        end
        EDIT: begin
          if (ev_adj) begin
            state    <= COMMIT;
            load_req <= 1'b1;
            editing  <= 1'b0;
          end else if (ev_mode) begin
            edit_field   <= field_nxt;
            display_sel  <= (field_nxt >= 3'd3) ? 2'd1 : 2'd0;
            display_year <= (field_nxt == 3'd5);
          end else if (ev_step) begin
            case (edit_field)
              3'd0: set_second <= sec_adj;
              3'd1: set_minute <= min_adj;
              3'd2: set_hour   <= hour_adj;
              3'd3: set_day    <= day_adj;
              3'd4: begin set_month <= month_adj; set_day <= day_m; end
              3'd5: begin set_year  <= year_adj;  set_day <= day_y; end
              default: ;
            endcase
          end
        end
        COMMIT: begin
          state        <= TIME_DISP;
          display_sel  <= 2'd0;
          display_year <= 1'b0;
        end
        default: state <= TIME_DISP;
      endcase
    end
  end

  always_comb begin
    blink_mask = 8'h00;
    if (editing && blink_off) begin
      case (edit_field)
        3'd0, 3'd3: blink_mask = 8'h03;
        3'd1, 3'd4: blink_mask = 8'h18;
        3'd2, 3'd5: blink_mask = 8'hC0;
        default:    blink_mask = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: display cycling, debounce, edit session,
// day clamping, press priority, blink timing and reset abort.
module tb_clock_mode_ctrl;
  localparam int DEB = 4;
  localparam int BLK = 16;
  localparam logic [3:0] ADJ = 4'b1000, MODE = 4'b0100, UP = 4'b0010, DN = 4'b0001;

  logic clk = 1'b0, rst_n = 1'b0;
  logic mode_btn = 1'b1, adjust_btn = 1'b1, up_btn = 1'b1, down_btn = 1'b1;
  logic [6:0] cur_year = '0;
  logic [3:0] cur_month = 4'd1;
  logic [4:0] cur_day = 5'd1, cur_hour = '0;
  logic [5:0] cur_minute = '0, cur_second = '0;
  logic [6:0] set_year;
  logic [3:0] set_month;
  logic [4:0] set_day, set_hour;
  logic [5:0] set_minute, set_second;
  logic       load_req, display_year, editing;
  logic [1:0] display_sel;
  logic [2:0] edit_field;
  logic [7:0] blink_mask;

  clock_mode_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .adjust_btn(adjust_btn),
    .up_btn(up_btn), .down_btn(down_btn), .cur_year(cur_year), .cur_month(cur_month),
    .cur_day(cur_day), .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .set_year(set_year), .set_month(set_month), .set_day(set_day), .set_hour(set_hour),
    .set_minute(set_minute), .set_second(set_second), .load_req(load_req),
    .display_sel(display_sel), .display_year(display_year), .editing(editing),
    .edit_field(edit_field), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int lr_count = 0, lr_run = 0, lr_max = 0;
  logic [32:0] cap_set;

  always @(negedge clk) begin
    if (load_req === 1'b1) begin
      lr_count++;
      lr_run++;
      if (lr_run > lr_max) lr_max = lr_run;
      cap_set = {set_year, set_month, set_day, set_hour, set_minute, set_second};
    end else begin
      lr_run = 0;
    end
  end

  task automatic drive(input logic [3:0] b);
    {adjust_btn, mode_btn, up_btn, down_btn} = ~b;
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk);
    drive(b);
    repeat (12) @(negedge clk);
    drive(4'b0000);
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (display_sel !== 2'd0) begin errors++; $display("FAIL reset_display_sel got %0d exp 0", display_sel); end
    checks++; if (display_year !== 1'b0) begin errors++; $display("FAIL reset_display_year got %0b exp 0", display_year); end
    checks++; if (editing !== 1'b0) begin errors++; $display("FAIL reset_editing got %0b exp 0", editing); end
    checks++; if (edit_field !== 3'd0) begin errors++; $display("FAIL reset_edit_field got %0d exp 0", edit_field); end
    checks++; if (load_req !== 1'b0) begin errors++; $display("FAIL reset_load_req got %0b exp 0", load_req); end
    checks++; if (blink_mask !== 8'h00) begin errors++; $display("FAIL reset_blink_mask got %h exp 00", blink_mask); end
    checks++;
    if ({set_year, set_month, set_day, set_hour, set_minute, set_second} !== {7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0}) begin
      errors++; $display("FAIL reset_set_fields got %0d-%0d-%0d %0d:%0d:%0d exp 0-1-1 0:0:0",
                         set_year, set_month, set_day, set_hour, set_minute, set_second);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mode_cycle;
    logic [1:0] exp_sel;
    for (int i = 0; i < 3; i++) begin
      press(MODE);
      exp_sel = 2'((i + 1) % 3);
      checks++; if (display_sel !== exp_sel) begin errors++; $display("FAIL mode_cycle_%0d got %0d exp %0d", i, display_sel, exp_sel); end
    end
    checks++; if (lr_count !== 0) begin errors++; $display("FAIL mode_cycle_no_load got %0d exp 0", lr_count); end
  endtask

  task automatic test_bounce;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      mode_btn = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    mode_btn = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (display_sel !== 2'd1) begin errors++; $display("FAIL bounce_held got %0d exp 1", display_sel); end
    mode_btn = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (display_sel !== 2'd1) begin errors++; $display("FAIL bounce_release got %0d exp 1", display_sel); end
    press(UP);
    checks++; if (display_year !== 1'b1) begin errors++; $display("FAIL date_year_up got %0b exp 1", display_year); end
    press(DN);
    checks++; if (display_year !== 1'b0) begin errors++; $display("FAIL date_year_down got %0b exp 0", display_year); end
    press(MODE);
    press(MODE);
    checks++; if (display_sel !== 2'd0) begin errors++; $display("FAIL bounce_back_to_time got %0d exp 0", display_sel); end
  endtask

  task automatic test_edit;
    int lrb;
    cur_year = 7'd23; cur_month = 4'd12; cur_day = 5'd31;
    cur_hour = 5'd23; cur_minute = 6'd59; cur_second = 6'd58;
    press(ADJ);
    checks++; if (editing !== 1'b1 || edit_field !== 3'd0) begin errors++; $display("FAIL edit_enter got editing=%0b field=%0d exp 1/0", editing, edit_field); end
    checks++;
    if ({set_year, set_month, set_day, set_hour, set_minute, set_second} !== {7'd23, 4'd12, 5'd31, 5'd23, 6'd59, 6'd58}) begin
      errors++; $display("FAIL edit_snapshot got %0d-%0d-%0d %0d:%0d:%0d exp 23-12-31 23:59:58",
                         set_year, set_month, set_day, set_hour, set_minute, set_second);
    end
    cur_second = 6'd5;
    repeat (5) @(negedge clk);
    checks++; if (set_second !== 6'd58) begin errors++; $display("FAIL edit_cur_isolated got %0d exp 58", set_second); end
    press(UP);
    press(UP);
    checks++; if (set_second !== 6'd0) begin errors++; $display("FAIL sec_wrap got %0d exp 0", set_second); end
    press(MODE);
    press(MODE);
    checks++; if (edit_field !== 3'd2 || display_sel !== 2'd0) begin errors++; $display("FAIL field_hour got field=%0d sel=%0d exp 2/0", edit_field, display_sel); end
    press(DN);
    checks++; if (set_hour !== 5'd22) begin errors++; $display("FAIL hour_down got %0d exp 22", set_hour); end
    lrb = lr_count;
    press(ADJ);
    checks++; if (lr_count !== lrb + 1 || lr_max !== 1) begin errors++; $display("FAIL commit_pulse got count=%0d run=%0d exp %0d/1", lr_count - lrb, lr_max, 1); end
    checks++; if (cap_set !== {7'd23, 4'd12, 5'd31, 5'd22, 6'd59, 6'd0}) begin errors++; $display("FAIL commit_values got %h exp %h", cap_set, {7'd23, 4'd12, 5'd31, 5'd22, 6'd59, 6'd0}); end
    checks++; if (display_sel !== 2'd0 || editing !== 1'b0 || load_req !== 1'b0) begin errors++; $display("FAIL after_commit got sel=%0d edit=%0b lr=%0b exp 0/0/0", display_sel, editing, load_req); end
  endtask

  task automatic test_day_clamp;
    int lrb;
    cur_year = 7'd24; cur_month = 4'd3; cur_day = 5'd31;
    cur_hour = 5'd5; cur_minute = 6'd0; cur_second = 6'd0;
    press(ADJ);
    for (int i = 0; i < 4; i++) press(MODE);
    checks++; if (edit_field !== 3'd4 || display_sel !== 2'd1 || display_year !== 1'b0) begin errors++; $display("FAIL field_month got field=%0d sel=%0d yr=%0b exp 4/1/0", edit_field, display_sel, display_year); end
    press(DN);
    checks++; if (set_month !== 4'd2 || set_day !== 5'd29) begin errors++; $display("FAIL month_clamp got %0d/%0d exp 2/29", set_month, set_day); end
    press(MODE);
    checks++; if (edit_field !== 3'd5 || display_year !== 1'b1) begin errors++; $display("FAIL field_year got field=%0d yr=%0b exp 5/1", edit_field, display_year); end
    press(UP);
    checks++; if (set_year !== 7'd25 || set_day !== 5'd28) begin errors++; $display("FAIL year_clamp got %0d/%0d exp 25/28", set_year, set_day); end
    press(MODE);
    checks++; if (edit_field !== 3'd0 || display_sel !== 2'd0) begin errors++; $display("FAIL field_wrap got field=%0d sel=%0d exp 0/0", edit_field, display_sel); end
    for (int i = 0; i < 3; i++) press(MODE);
    press(UP);
    checks++; if (set_day !== 5'd1) begin errors++; $display("FAIL day_wrap got %0d exp 1", set_day); end
    lrb = lr_count;
    press(ADJ);
    checks++; if (lr_count !== lrb + 1) begin errors++; $display("FAIL clamp_commit got %0d exp %0d", lr_count, lrb + 1); end
    checks++; if (cap_set !== {7'd25, 4'd2, 5'd1, 5'd5, 6'd0, 6'd0}) begin errors++; $display("FAIL clamp_values got %h exp %h", cap_set, {7'd25, 4'd2, 5'd1, 5'd5, 6'd0, 6'd0}); end
  endtask

  task automatic test_blink;
    logic [7:0] last;
    int run, changes;
    last = blink_mask; run = 0; changes = 0;
    for (int i = 0; i < 5 * BLK; i++) begin
      @(negedge clk);
      checks++; if (blink_mask !== 8'h00 && blink_mask !== 8'h03) begin errors++; $display("FAIL blink_value got %h exp 00 or 03", blink_mask); end
      if (blink_mask !== last) begin
        if (changes > 0) begin
          checks++; if (run !== BLK) begin errors++; $display("FAIL blink_period got %0d exp %0d", run, BLK); end
        end
        changes++; run = 1; last = blink_mask;
      end else begin
        run++;
      end
    end
    checks++; if (changes < 3) begin errors++; $display("FAIL blink_toggles got %0d exp >=3", changes); end
  endtask

  task automatic test_priority;
    cur_year = 7'd10; cur_month = 4'd6; cur_day = 5'd15;
    cur_hour = 5'd8; cur_minute = 6'd10; cur_second = 6'd30;
    press(ADJ | UP);
    checks++; if (editing !== 1'b1 || edit_field !== 3'd0 || set_second !== 6'd30) begin errors++; $display("FAIL prio_adj_up got edit=%0b field=%0d sec=%0d exp 1/0/30", editing, edit_field, set_second); end
    test_blink();
    press(MODE | DN);
    checks++; if (edit_field !== 3'd1 || set_minute !== 6'd10 || set_second !== 6'd30) begin errors++; $display("FAIL prio_mode_down got field=%0d min=%0d sec=%0d exp 1/10/30", edit_field, set_minute, set_second); end
  endtask

  task automatic test_reset_mid_edit;
    int lrb;
    press(UP);
    checks++; if (set_minute !== 6'd11) begin errors++; $display("FAIL min_up got %0d exp 11", set_minute); end
    lrb = lr_count;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (editing !== 1'b0 || edit_field !== 3'd0 || display_sel !== 2'd0 || display_year !== 1'b0) begin errors++; $display("FAIL abort_ctrl got edit=%0b field=%0d sel=%0d yr=%0b exp 0/0/0/0", editing, edit_field, display_sel, display_year); end
    checks++; if (blink_mask !== 8'h00 || load_req !== 1'b0) begin errors++; $display("FAIL abort_mask got mask=%h lr=%0b exp 00/0", blink_mask, load_req); end
    checks++;
    if ({set_year, set_month, set_day, set_hour, set_minute, set_second} !== {7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0}) begin
      errors++; $display("FAIL abort_set_fields got %0d-%0d-%0d %0d:%0d:%0d exp 0-1-1 0:0:0",
                         set_year, set_month, set_day, set_hour, set_minute, set_second);
    end
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (lr_count !== lrb || editing !== 1'b0) begin errors++; $display("FAIL abort_no_load got loads=%0d edit=%0b exp 0/0", lr_count - lrb, editing); end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_bounce();
    test_edit();
    test_day_clamp();
    test_priority();
    test_reset_mid_edit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Button-driven controller for the digital clock. It sequences display modes (time, date, weekday) and runs the field-by-field time/date edit session.
- On commit it issues a one-cycle load request carrying broken-down fields. The date-to-unix converter in front of unixCounter consumes that request.
- It sits between the raw push-buttons and the unixCounter / counter2bcd / ledScan datapath.
- It drives display selection, year display and digit blink masks.

Parameters:
- DEBOUNCE_CYCLES, 1000000, stable-level cycles required before a button change is accepted (10 ms at 100 MHz).
- BLINK_CYCLES, 50000000, half-period of edit-field blink in clk cycles.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- mode_btn  input  1  raw button, active-low, asynchronous to clk
- adjust_btn  input  1  raw button, active-low
- up_btn  input  1  raw button, active-low
- down_btn  input  1  raw button, active-low
- cur_year  input  7  current year offset from 2000 (0..99)
- cur_month  input  4  current month 1..12
- cur_day  input  5  current day 1..31
- cur_hour  input  5  current hour 0..23
- cur_minute  input  6  current minute 0..59
- cur_second  input  6  current second 0..59
- set_year, set_month, set_day, set_hour, set_minute, set_second  output  7/4/5/5/6/6  edit registers, valid while load_req=1
- load_req  output  1  one-cycle commit strobe
- display_sel  output  2  0=time, 1=date, 2=weekday
- display_year  output  1  1 = show year digits in date view
- editing  output  1  high in EDIT state
- edit_field  output  3  0=sec, 1=min, 2=hour, 3=day, 4=month, 5=year
- blink_mask  output  8  1 = blank that digit this cycle

Behaviour:
- Button front end, per button:
  - 2-FF synchroniser, then a debounce counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A 1→0 transition of the accepted level produces a one-cycle press pulse.
- Press pulse latency: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Simultaneous pulses in one cycle: priority adjust > mode > up > down. Lower-priority pulses in that cycle are dropped.
- Reset values:
  - state TIME_DISP, edit_field 0, load_req 0, display_sel 0, display_year 0, editing 0, blink_mask 0.
  - set_* = 2000-01-01 00:00:00 (year 0, month 1, day 1, hour 0, minute 0, second 0).
  - Debounce counters 0; accepted levels 1 (released).
- FSM states: TIME_DISP, DATE_DISP, WEEK_DISP, EDIT, COMMIT.
- mode press in the display states cycles TIME_DISP → DATE_DISP → WEEK_DISP → TIME_DISP.
- up or down press in DATE_DISP toggles display_year. display_year is forced to 0 in the other display states.
- adjust press in any display state:
  - Snapshots cur_* into set_* on the same edge.
  - edit_field=0, go to EDIT.
- EDIT:
  - mode press advances edit_field 0→1→2→3→4→5→0.
  - up/down increments or decrements the selected field with wrap:
    - sec and min 0..59, hour 0..23, month 1..12, year 0..99.
    - day 1..dim, where dim = days in set_month for set_year. Leap year when set_year[1:0]==0.
  - After any month or year change, if set_day > new dim, set_day clamps to dim in the same cycle.
  - adjust press goes to COMMIT.
- COMMIT lasts exactly one cycle:
  - load_req=1 with set_* stable.
  - Next state TIME_DISP; load_req returns to 0.
- While editing, cur_* changes do not affect set_*. The clock keeps running; the committed values overwrite it.
- display_sel in EDIT: 0 for fields 0-2, 1 for fields 3-5. display_year=1 only for field 5.
- Blink:
  - A free-running counter toggles the phase every BLINK_CYCLES. It resets to the on-phase on entering EDIT.
  - blink_mask during the off-phase: field0/3 → 8'h03, field1/4 → 8'h18, field2/5 → 8'hC0. Mask is 0 in the on-phase and outside EDIT.
- Reset asserted mid-edit discards all edits; no load_req is issued.
- A button held down generates exactly one pulse. There is no auto-repeat.

Test Plan:
- Reset, then press mode 3 times (DEBOUNCE_CYCLES=4 in bench) → display_sel 0→1→2→0; load_req never asserted.
- Bounce: toggle mode_btn every 2 cycles for 20 cycles, then hold low → exactly one press pulse, display_sel advances by 1.
- cur=2023-12-31 23:59:58; press adjust → set_*=that snapshot. Then:
  - up on sec twice → second=0 (wraps from 59).
  - mode ×2, down on hour → hour=22.
  - adjust → single load_req cycle with 2023-12-31 22:59:00, then display_sel=0.
- Day clamp: snapshot 2024-03-31.
  - Select month, down → month=2, day clamps to 29.
  - Select year, up → year=25, day clamps to 28.
  - Day up from 28 → 1.
- Priority: adjust and up pressed in the same cycle from TIME_DISP → enter EDIT, field 0 unchanged. Then, in EDIT (field 0), pulse mode and down in the same cycle → edit_field advances to 1, minute unchanged.
- Assert rst_n mid-edit → all outputs return to reset values, load_req stays 0. In EDIT, blink_mask alternates 8'h00 and 8'h03 every BLINK_CYCLES on field 0.
